count_sched: RTL and testbench

Interval scheduler that shares one 4-bit T-flip-flop-style up-counter between two requesters. Each requester asks for a run of a programmable length. The block arbitrates round-robin, grants one requester at a time, and runs the counter from 0 to that requester's terminal count. It reports completion with a one-cycle done pulse. It sits between the counter datapath and the two client blocks that need timed intervals.

---
 rtl/count_sched.sv | 106 ++++++++++
 tb/tb_count_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module   : count_sched
// Purpose  : Round-robin interval scheduler sharing one up-counter between two
//            requesters; runs 0..len for the granted client, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module count_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rs,
    input  logic [1:0]   req,
    input  logic [W-1:0] len0,
    input  logic [W-1:0] len1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic [W-1:0] q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q;
    logic [1:0]   gnt_q;
    logic [1:0]   done_q;
    logic         busy_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] len_q;
    logic         last_q;   // index of the most recently granted requester
    logic         sel_d;    // requester that would win a grant this cycle

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        sel_d = req[1];
        if (req == 2'b11) begin
            sel_d = ~last_q;
        end
    end

    // Scheduler FSM; every output is a register so req/len never reach outputs
    always_ff @(posedge clk) begin
        if (rs) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 2'b00;
                    if (req != 2'b00) begin
                        state_q <= S_RUN;
                        gnt_q   <= sel_d ? 2'b10 : 2'b01;
                        len_q   <= sel_d ? len1 : len0;
                        cnt_q   <= '0;
                        last_q  <= sel_d;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // last_q names the granted requester for the whole run
                    if (!req[last_q]) begin
                        state_q <= S_IDLE;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign q    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_count_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sched
// Purpose  : Self-checking bench for count_sched; each queued entry pairs the
//            inputs for one clock edge with the outputs expected after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_sched;

    logic       clk;
    logic       rs;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] q;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       rs;
        logic [1:0] req;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] g;
        logic [1:0] d;
        logic       b;
        logic [3:0] q;
    } ent_t;

    ent_t sb[$];

    count_sched #(.W(4)) dut (
        .clk  (clk),
        .rs   (rs),
        .req  (req),
        .len0 (len0),
        .len1 (len1),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic push(input logic r, input logic [1:0] rq, input logic [3:0] l0,
                        input logic [3:0] l1, input logic [1:0] g, input logic [1:0] d,
                        input logic b, input logic [3:0] qv);
        ent_t e;
        e.rs = r; e.req = rq; e.l0 = l0; e.l1 = l1;
        e.g = g; e.d = d; e.b = b; e.q = qv;
        sb.push_back(e);
    endtask

    // Apply each entry before an edge, then compare outputs 1 time unit after it
    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            rs   = e.rs;
            req  = e.req;
            len0 = e.l0;
            len1 = e.l1;
            @(posedge clk);
            #1;
            check("gnt",  {30'd0, gnt},  {30'd0, e.g});
            check("done", {30'd0, done}, {30'd0, e.d});
            check("busy", {31'd0, busy}, {31'd0, e.b});
            check("q",    {28'd0, q},    {28'd0, e.q});
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rs = 1'b1; req = 2'b00; len0 = 4'd0; len1 = 4'd0;

        // Reset state
        push(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        push(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        drain();

        // Single request, len0=3: q 0,1,2,3,3 with done in the 5th cycle
        push(0, 2'b01, 3, 0, 2'b01, 2'b00, 1, 0);
        push(0, 2'b01, 3, 0, 2'b01, 2'b00, 1, 1);
        push(0, 2'b01, 3, 0, 2'b01, 2'b00, 1, 2);
        push(0, 2'b01, 3, 0, 2'b01, 2'b00, 1, 3);
        push(0, 2'b01, 3, 0, 2'b01, 2'b01, 1, 3);
        push(0, 2'b00, 3, 0, 2'b00, 2'b00, 0, 3);
        push(0, 2'b00, 3, 0, 2'b00, 2'b00, 0, 3);
        drain();

        // Tie from reset: requester 0 first, then 1 (len1=0), then 0 again
        push(1, 2'b00, 2, 0, 2'b00, 2'b00, 0, 0);
        push(0, 2'b11, 2, 0, 2'b01, 2'b00, 1, 0);
        push(0, 2'b11, 2, 0, 2'b01, 2'b00, 1, 1);
        push(0, 2'b11, 2, 0, 2'b01, 2'b00, 1, 2);
        push(0, 2'b11, 2, 0, 2'b01, 2'b01, 1, 2);
        push(0, 2'b11, 2, 0, 2'b00, 2'b00, 0, 2);
        push(0, 2'b11, 2, 0, 2'b10, 2'b00, 1, 0);
        push(0, 2'b11, 2, 0, 2'b10, 2'b10, 1, 0);
        push(0, 2'b11, 2, 0, 2'b00, 2'b00, 0, 0);
        push(0, 2'b11, 2, 0, 2'b01, 2'b00, 1, 0);
        // dropping req0 right after its grant aborts the run
        push(0, 2'b00, 2, 0, 2'b00, 2'b00, 0, 0);
        push(0, 2'b00, 2, 0, 2'b00, 2'b00, 0, 0);
        drain();

        // len0=15: q climbs to 15 without wrapping, done in the 17th grant cycle
        push(0, 2'b01, 15, 0, 2'b01, 2'b00, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            push(0, 2'b01, 15, 0, 2'b01, 2'b00, 1, 4'(i));
        end
        push(0, 2'b01, 15, 0, 2'b01, 2'b01, 1, 15);
        push(0, 2'b00, 15, 0, 2'b00, 2'b00, 0, 15);
        push(0, 2'b00, 15, 0, 2'b00, 2'b00, 0, 15);
        drain();

        // Abort at q=4 while req1 waits; req1 (len1=1) is granted next cycle
        push(0, 2'b01, 9, 1, 2'b01, 2'b00, 1, 0);
        push(0, 2'b11, 9, 1, 2'b01, 2'b00, 1, 1);
        push(0, 2'b11, 9, 1, 2'b01, 2'b00, 1, 2);
        push(0, 2'b11, 9, 1, 2'b01, 2'b00, 1, 3);
        push(0, 2'b11, 9, 1, 2'b01, 2'b00, 1, 4);
        push(0, 2'b10, 9, 1, 2'b00, 2'b00, 0, 0);
        push(0, 2'b10, 9, 1, 2'b10, 2'b00, 1, 0);
        push(0, 2'b10, 9, 1, 2'b10, 2'b00, 1, 1);
        push(0, 2'b10, 9, 1, 2'b10, 2'b10, 1, 1);
        push(0, 2'b00, 9, 1, 2'b00, 2'b00, 0, 1);
        drain();

        // len0 sampled only at grant: changing 3 -> 10 afterwards has no effect
        push(0, 2'b01, 3,  0, 2'b01, 2'b00, 1, 0);
        push(0, 2'b01, 10, 0, 2'b01, 2'b00, 1, 1);
        push(0, 2'b01, 10, 0, 2'b01, 2'b00, 1, 2);
        push(0, 2'b01, 10, 0, 2'b01, 2'b00, 1, 3);
        push(0, 2'b01, 10, 0, 2'b01, 2'b01, 1, 3);
        push(0, 2'b00, 10, 0, 2'b00, 2'b00, 0, 3);
        drain();

        // Reset held 2 cycles mid-run at q=5; no done ever appears afterwards
        push(0, 2'b01, 9, 0, 2'b01, 2'b00, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            push(0, 2'b01, 9, 0, 2'b01, 2'b00, 1, 4'(i));
        end
        push(1, 2'b00, 9, 0, 2'b00, 2'b00, 0, 0);
        push(1, 2'b00, 9, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 12; i++) begin
            push(0, 2'b00, 9, 0, 2'b00, 2'b00, 0, 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
